// File: rtl/deserializer.sv
// Serial-to-parallel converter: collects qualified serial bits into a DATA_W-bit
// word and presents each completed word with a single-cycle valid pulse.
// Bit order is fixed at elaboration by MSB_FIRST. Gaps between bits are tolerated.
module deserializer #(
  parameter int unsigned DATA_W    = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic              deser_data_val_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_data;
  logic              r_val;

  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_shreg_next;
  logic              w_word_done;

  // Next-state shift value and bit counter for an accepted bit.
  always_comb begin
    w_shreg_next = r_shreg;
    w_cnt_next   = r_cnt;
    w_word_done  = 1'b0;
    if (data_val_i) begin
      if (MSB_FIRST) begin
        w_shreg_next = {r_shreg[DATA_W-2:0], data_i};
      end else begin
        w_shreg_next = {data_i, r_shreg[DATA_W-1:1]};
      end
      if (r_cnt == CntMax) begin
        w_cnt_next  = '0;
        w_word_done = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // Shift register and counter; reset discards any partial word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_shreg <= w_shreg_next;
    end
  end

  // Output word and pulse; the word is taken from the next-state shift value so
  // that the completing bit is included.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_data <= '0;
      r_val  <= 1'b0;
    end else begin
      r_val <= w_word_done;
      if (w_word_done) begin
        r_data <= w_shreg_next;
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_val_o = r_val;

endmodule

// File: tb/tb_deserializer.sv
// Directed self-checking bench for deserializer. Two instances share the same
// serial stimulus: one MSB-first and one LSB-first.
module tb_deserializer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         srst;
  logic         din;
  logic         dval;
  logic [W-1:0] q_m;
  logic [W-1:0] q_l;
  logic         v_m;
  logic         v_l;

  int n_checks = 0;
  int n_errors = 0;
  int pulses_m = 0;
  int pulses_l = 0;
  int bad      = 0;
  int pm;
  int pl;

  always #5 clk = ~clk;

  deserializer #(
    .DATA_W   (W),
    .MSB_FIRST(1'b1)
  ) u_msb (
    .clk_i           (clk),
    .srst_i          (srst),
    .data_i          (din),
    .data_val_i      (dval),
    .deser_data_o    (q_m),
    .deser_data_val_o(v_m)
  );

  deserializer #(
    .DATA_W   (W),
    .MSB_FIRST(1'b0)
  ) u_lsb (
    .clk_i           (clk),
    .srst_i          (srst),
    .data_i          (din),
    .data_val_i      (dval),
    .deser_data_o    (q_l),
    .deser_data_val_o(v_l)
  );

  // Count valid pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (v_m) pulses_m++;
    if (v_l) pulses_l++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic step(input logic b, input logic v, input logic r);
    srst = r;
    din  = b;
    dval = v;
    @(posedge clk);
    #1;
  endtask

  // Send the top nbits of w, MSB first, with gap idle cycles between bits.
  // Until the last bit, both outputs must hold the given values with no pulse.
  task automatic feed(input logic [15:0] w, input int nbits, input int gap,
                      input logic [15:0] hold_m, input logic [15:0] hold_l);
    for (int i = 0; i < nbits; i++) begin
      step(w[15-i], 1'b1, 1'b0);
      if (i < nbits - 1) begin
        if (v_m || v_l || q_m !== hold_m || q_l !== hold_l) bad++;
        for (int g = 0; g < gap; g++) begin
          step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
          if (v_m || v_l || q_m !== hold_m || q_l !== hold_l) bad++;
        end
      end
    end
  endtask

  function automatic logic [15:0] left_bit(input logic [15:0] w);
    left_bit = '0;
    for (int i = 0; i < 16; i++) begin
      if (w[i]) left_bit = 16'(1) << i;
    end
  endfunction

  function automatic logic [15:0] right_bit(input logic [15:0] w);
    right_bit = w & (~w + 16'd1);
  endfunction

  initial begin
    srst = 1'b1;
    din  = 1'b0;
    dval = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("reset_data_m", q_m, 0);
    check("reset_val_m", v_m, 0);
    check("reset_data_l", q_l, 0);
    check("reset_val_l", v_l, 0);
    step(1'b0, 1'b0, 1'b0);

    // Continuous word, both bit orders.
    pm = pulses_m; pl = pulses_l; bad = 0;
    feed(16'hA5C3, 16, 0, 16'h0000, 16'h0000);
    check("cont_val_m", v_m, 1);
    check("cont_data_m", q_m, 16'hA5C3);
    check("cont_val_l", v_l, 1);
    check("cont_data_l", q_l, 16'hC3A5);
    check("cont_early", bad, 0);
    step(1'b0, 1'b0, 1'b0);
    check("cont_single", v_m, 0);
    check("cont_hold", q_m, 16'hA5C3);
    check("cont_pulses_m", pulses_m - pm, 1);
    check("cont_pulses_l", pulses_l - pl, 1);

    // Gapped input with random data during the gaps.
    pm = pulses_m; bad = 0;
    feed(16'h0001, 16, 3, 16'hA5C3, 16'hC3A5);
    check("gap_val", v_m, 1);
    check("gap_data_m", q_m, 16'h0001);
    check("gap_data_l", q_l, 16'h8000);
    check("gap_early", bad, 0);
    step(1'b0, 1'b0, 1'b0);
    check("gap_pulses", pulses_m - pm, 1);

    // Back-to-back words, no idle between them.
    pm = pulses_m; bad = 0;
    feed(16'hFFFF, 16, 0, 16'h0001, 16'h8000);
    check("b2b_val1", v_m, 1);
    check("b2b_data1", q_m, 16'hFFFF);
    feed(16'h8000, 16, 0, 16'hFFFF, 16'hFFFF);
    check("b2b_val2", v_m, 1);
    check("b2b_data2_m", q_m, 16'h8000);
    check("b2b_data2_l", q_l, 16'h0001);
    check("b2b_hold", bad, 0);
    step(1'b0, 1'b0, 1'b0);
    check("b2b_pulses", pulses_m - pm, 2);

    // Reset mid-word; the bit presented with reset is dropped.
    pm = pulses_m; bad = 0;
    feed(16'h1234, 9, 0, 16'h8000, 16'h0001);
    step(1'b1, 1'b1, 1'b1);
    check("rst_data_m", q_m, 0);
    check("rst_val_m", v_m, 0);
    check("rst_data_l", q_l, 0);
    feed(16'h00F0, 16, 0, 16'h0000, 16'h0000);
    check("rst_val", v_m, 1);
    check("rst_word_m", q_m, 16'h00F0);
    check("rst_word_l", q_l, 16'h0F00);
    check("rst_partial", bad, 0);
    step(1'b0, 1'b0, 1'b0);
    check("rst_pulses", pulses_m - pm, 1);

    // Completing bit coincides with reset: word lost, next word realigned.
    pm = pulses_m; bad = 0;
    feed(16'hFFFF, 15, 0, 16'h00F0, 16'h0F00);
    step(1'b1, 1'b1, 1'b1);
    check("lost_val", v_m, 0);
    check("lost_data", q_m, 0);
    step(1'b0, 1'b0, 1'b0);
    check("lost_nopulse", v_m, 0);
    feed(16'h0810, 16, 1, 16'h0000, 16'h0000);
    check("enc_val", v_m, 1);
    check("enc_data_m", q_m, 16'h0810);
    check("enc_data_l", q_l, 16'h0810);
    check("enc_left", left_bit(q_m), 16'h0800);
    check("enc_right", right_bit(q_m), 16'h0010);
    check("enc_quiet", bad, 0);
    step(1'b0, 1'b0, 1'b0);
    check("enc_pulses", pulses_m - pm, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
